// File: rtl/hetszegmens_multiplex_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package hetszegmens_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_e;

  function automatic int seg_width();
    return 7;
  endfunction

endpackage

// File: rtl/hetszegmens_multiplex_bin2hetszegmens.sv
// Hex nibble to 7-segment pattern decoder (a..g = bit6..bit0, active high).
module bin2hetszegmens
  import hetszegmens_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_OFF;
    case (nibble)
      4'h0: segments = 7'h7E;
      4'h1: segments = 7'h30;
      4'h2: segments = 7'h6D;
      4'h3: segments = 7'h79;
      4'h4: segments = 7'h33;
      4'h5: segments = 7'h5B;
      4'h6: segments = 7'h5F;
      4'h7: segments = 7'h70;
      4'h8: segments = 7'h7F;
      4'h9: segments = 7'h7B;
      4'hA: segments = 7'h77;
      4'hB: segments = 7'h1F;
      4'hC: segments = 7'h4E;
      4'hD: segments = 7'h3D;
      4'hE: segments = 7'h4F;
      4'hF: segments = 7'h47;
      default: segments = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/hetszegmens_multiplex.sv
// Time-multiplexed scan controller: double-buffered frame value, blanking gap per slot,
// one shared decoder, all display outputs registered.
module hetszegmens_multiplex
  import hetszegmens_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [DIGITS-1:0]     load_blank,
  output logic [6:0]            output_segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SEG_W = seg_width();
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  logic [SW-1:0]       slot_cnt_reg, slot_cnt_next;
  logic [DW-1:0]       digit_idx_reg, digit_idx_next;
  scan_state_e         state_reg, state_next;
  logic [4*DIGITS-1:0] active_value_reg, active_value_next, pending_value_reg;
  logic [DIGITS-1:0]   active_blank_reg, active_blank_next, pending_blank_reg;
  logic                pending_full_reg;
  logic [SEG_W-1:0]    seg_reg, seg_next, seg_decoded;
  logic [DIGITS-1:0]   en_reg, en_next;
  logic                done_reg, done_next;
  logic                slot_wrap, frame_wrap, accept, commit;
  logic [3:0]          nibble_arr [DIGITS];
  logic [3:0]          nibble_sel;

  assign slot_wrap  = (slot_cnt_reg == SLOT_LAST);
  assign frame_wrap = slot_wrap && (digit_idx_reg == DIGIT_LAST);
  assign accept     = load_valid && !pending_full_reg;
  assign commit     = frame_wrap && pending_full_reg;

  // Outputs are computed from next-cycle state so the registered pins line up with slot_cnt.
  assign active_value_next = commit ? pending_value_reg : active_value_reg;
  assign active_blank_next = commit ? pending_blank_reg : active_blank_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_reg  <= '0;
      digit_idx_reg <= '0;
      state_reg     <= BLANK;
    end else begin
      slot_cnt_reg  <= slot_cnt_next;
      digit_idx_reg <= digit_idx_next;
      state_reg     <= state_next;
    end
  end

  always_comb begin
    slot_cnt_next  = slot_wrap ? '0 : slot_cnt_reg + 1'b1;
    digit_idx_next = digit_idx_reg;
    if (slot_wrap) begin
      digit_idx_next = (digit_idx_reg == DIGIT_LAST) ? '0 : digit_idx_reg + 1'b1;
    end
    state_next = (int'(slot_cnt_next) < BLANK_CYCLES) ? BLANK : SHOW;
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
      assign nibble_arr[gi] = active_value_next[4*gi +: 4];
    end
  endgenerate

  assign nibble_sel = nibble_arr[digit_idx_next];

  bin2hetszegmens u_decoder (
    .nibble   (nibble_sel),
    .segments (seg_decoded)
  );

  always_comb begin
    seg_next  = SEG_OFF;
    en_next   = '0;
    done_next = (slot_cnt_next == SLOT_LAST) && (digit_idx_next == DIGIT_LAST);
    if (state_next == SHOW && !active_blank_next[digit_idx_next]) begin
      seg_next                = seg_decoded;
      en_next[digit_idx_next] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_value_reg  <= '0;
      active_blank_reg  <= '0;
      pending_value_reg <= '0;
      pending_blank_reg <= '0;
      pending_full_reg  <= 1'b0;
      seg_reg           <= SEG_OFF;
      en_reg            <= '0;
      done_reg          <= 1'b0;
    end else begin
      active_value_reg <= active_value_next;
      active_blank_reg <= active_blank_next;
      if (accept) begin
        pending_value_reg <= load_value;
        pending_blank_reg <= load_blank;
        pending_full_reg  <= 1'b1;
      end else if (commit) begin
        pending_full_reg <= 1'b0;
      end
      seg_reg  <= seg_next;
      en_reg   <= en_next;
      done_reg <= done_next;
    end
  end

  assign load_ready      = !pending_full_reg;
  assign output_segments = seg_reg;
  assign digit_en        = en_reg;
  assign frame_done      = done_reg;

endmodule

// File: tb/tb_hetszegmens_multiplex.sv
// Scoreboarded bench for hetszegmens_multiplex with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_hetszegmens_multiplex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic [3:0]  load_blank;
  logic [6:0]  output_segments;
  logic [3:0]  digit_en;
  logic        frame_done;

  hetszegmens_multiplex #(
    .DIGITS       (4),
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_value      (load_value),
    .load_blank      (load_blank),
    .output_segments (output_segments),
    .digit_en        (digit_en),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  blank;
    int          start;
  } frame_t;

  frame_t sb[$];
  frame_t cur;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc = 0;
  bit     mon_on = 0;

  logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [6:0] exp_12af [4] = '{7'h47, 7'h77, 7'h6D, 7'h30};

  // Cycle index since reset release; equals the DUT's slot position within the frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int         m_c, m_slot, m_dig;
  logic [3:0] m_nib, en_e;
  logic [6:0] seg_e;
  logic       done_e, rdy_e;
  frame_t     m_new;

  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      m_c = cyc;
      if (sb.size() > 0 && sb[0].start == m_c) begin
        cur = sb.pop_front();
        $display("cycle %0d: frame now shows value %h blank %b", m_c, cur.val, cur.blank);
      end
      m_slot = m_c % 8;
      m_dig  = (m_c / 8) % 4;
      m_nib  = cur.val[4*m_dig +: 4];
      if (m_slot < 2 || cur.blank[m_dig]) begin
        en_e  = 4'b0000;
        seg_e = 7'h00;
      end else begin
        en_e  = 4'b0001 << m_dig;
        seg_e = tbl[m_nib];
      end
      done_e = ((m_c % 32) == 31);
      rdy_e  = (sb.size() == 0);
      n_cmp++;
      if (digit_en !== en_e) begin
        n_bad++;
        $display("FAIL scan_en cycle %0d: got %b expected %b", m_c, digit_en, en_e);
      end
      n_cmp++;
      if (output_segments !== seg_e) begin
        n_bad++;
        $display("FAIL scan_seg cycle %0d: got %h expected %h", m_c, output_segments, seg_e);
      end
      n_cmp++;
      if (frame_done !== done_e) begin
        n_bad++;
        $display("FAIL scan_done cycle %0d: got %b expected %b", m_c, frame_done, done_e);
      end
      n_cmp++;
      if (load_ready !== rdy_e) begin
        n_bad++;
        $display("FAIL scan_ready cycle %0d: got %b expected %b", m_c, load_ready, rdy_e);
      end
      if (load_valid && load_ready) begin
        m_new.val   = load_value;
        m_new.blank = load_blank;
        m_new.start = ((m_c % 32) == 31) ? (m_c / 32 + 2) * 32 : (m_c / 32 + 1) * 32;
        sb.push_back(m_new);
        $display("cycle %0d: load %h blank %b accepted, visible from cycle %0d",
                 m_c, load_value, load_blank, m_new.start);
      end
    end
  end

  task automatic advance_to(input int m, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (load_ready && (cyc % 32) == m) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    int p1, p2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (output_segments !== 7'h00) begin n_bad++; $display("FAIL reset_seg: got %h expected 00", output_segments); end
    n_cmp++;
    if (digit_en !== 4'b0000) begin n_bad++; $display("FAIL reset_en: got %b expected 0000", digit_en); end
    n_cmp++;
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    n_cmp++;
    if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", load_ready); end
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1;
    wait_cycle(2);
    n_cmp++;
    if (digit_en !== 4'b0001 || output_segments !== 7'h7E) begin
      n_bad++;
      $display("FAIL first_show: got en %b seg %h expected en 0001 seg 7e", digit_en, output_segments);
    end
    p1 = -1;
    p2 = -1;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (frame_done) begin
        if (p1 < 0) p1 = cyc;
        else begin p2 = cyc; break; end
      end
    end
    n_cmp++;
    if (p1 != 31 || p2 - p1 != 32) begin
      n_bad++;
      $display("FAIL frame_period: got pulses at %0d and %0d expected 31 and 63", p1, p2);
    end
  endtask

  task automatic test_load;
    bit ok;
    int fs;
    advance_to(10, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL load_wait: got no ready slot expected one"); end
    load_value = 16'h12AF;
    load_blank = 4'b0000;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_low: got %b expected 0", load_ready); end
    for (int i = 0; i < 40 && !frame_done; i++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if ((cyc % 32) != 31 || frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL load_boundary: got cycle %0d done %b expected frame end", cyc, frame_done);
    end
    fs = cyc + 1;
    for (int d = 0; d < 4; d++) begin
      wait_cycle(fs + 8 * d + 4);
      n_cmp++;
      if (output_segments !== exp_12af[d] || digit_en !== (4'b0001 << d)) begin
        n_bad++;
        $display("FAIL load_digit%0d: got seg %h en %b expected seg %h", d, output_segments, digit_en, exp_12af[d]);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int acc;
    advance_to(5, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_wait: got no ready slot expected one"); end
    load_value = 16'h5678;
    load_blank = 4'b0000;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_value = 16'h3333;
    for (int i = 0; i < 80 && !load_ready; i++) begin
      @(posedge clk); #1;
    end
    acc = cyc;
    @(posedge clk); #1;
    load_valid = 1'b0;
    n_cmp++;
    if ((acc % 32) != 0) begin n_bad++; $display("FAIL b2b_accept: got cycle mod 32 = %0d expected 0", acc % 32); end
    n_cmp++;
    if (load_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_pending: got ready %b expected 0", load_ready); end
    wait_cycle(acc + 4);
    n_cmp++;
    if (output_segments !== 7'h7F) begin n_bad++; $display("FAIL b2b_first: got %h expected 7f", output_segments); end
    wait_cycle(acc + 36);
    n_cmp++;
    if (output_segments !== 7'h79) begin n_bad++; $display("FAIL b2b_second: got %h expected 79", output_segments); end
  endtask

  task automatic test_blank;
    bit ok;
    int fs;
    advance_to(6, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL blank_wait: got no ready slot expected one"); end
    fs = (cyc / 32 + 1) * 32;
    load_value = 16'h4321;
    load_blank = 4'b1000;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    wait_cycle(fs + 12);
    n_cmp++;
    if (digit_en !== 4'b0010 || output_segments !== 7'h6D) begin
      n_bad++;
      $display("FAIL blank_digit1: got en %b seg %h expected en 0010 seg 6d", digit_en, output_segments);
    end
    wait_cycle(fs + 20);
    n_cmp++;
    if (digit_en !== 4'b0100 || output_segments !== 7'h79) begin
      n_bad++;
      $display("FAIL blank_digit2: got en %b seg %h expected en 0100 seg 79", digit_en, output_segments);
    end
    wait_cycle(fs + 28);
    n_cmp++;
    if (digit_en !== 4'b0000 || output_segments !== 7'h00) begin
      n_bad++;
      $display("FAIL blank_digit3: got en %b seg %h expected en 0000 seg 00", digit_en, output_segments);
    end
  endtask

  task automatic test_boundary_load;
    bit ok;
    int c0;
    advance_to(31, ok);
    n_cmp++;
    if (!ok || frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL bnd_wait: got ok %0d done %b expected boundary with ready", ok, frame_done);
    end
    c0 = cyc;
    load_value = 16'h9ABC;
    load_blank = 4'b0000;
    load_valid = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    n_cmp++;
    if (load_ready !== 1'b0) begin n_bad++; $display("FAIL bnd_pending: got ready %b expected 0", load_ready); end
    wait_cycle(c0 + 3);
    n_cmp++;
    if (output_segments !== 7'h30) begin n_bad++; $display("FAIL bnd_old: got %h expected 30", output_segments); end
    wait_cycle(c0 + 35);
    n_cmp++;
    if (output_segments !== 7'h4E) begin n_bad++; $display("FAIL bnd_new: got %h expected 4e", output_segments); end
    wait_cycle(c0 + 59);
    n_cmp++;
    if (digit_en !== 4'b1000 || output_segments !== 7'h7B) begin
      n_bad++;
      $display("FAIL bnd_digit3: got en %b seg %h expected en 1000 seg 7b", digit_en, output_segments);
    end
  endtask

  task automatic test_async_reset;
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (digit_en !== 4'b0000) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ar_show: got en %b expected nonzero", digit_en); end
    #2;
    rst_n  = 1'b0;
    mon_on = 0;
    #1;
    n_cmp++;
    if (digit_en !== 4'b0000 || output_segments !== 7'h00) begin
      n_bad++;
      $display("FAIL ar_immediate: got en %b seg %h expected 0000 00", digit_en, output_segments);
    end
    n_cmp++;
    if (load_ready !== 1'b1 || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_ctrl: got ready %b done %b expected 1 0", load_ready, frame_done);
    end
    sb.delete();
    cur.val   = '0;
    cur.blank = '0;
    cur.start = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1;
    wait_cycle(2);
    n_cmp++;
    if (digit_en !== 4'b0001 || output_segments !== 7'h7E) begin
      n_bad++;
      $display("FAIL ar_restart: got en %b seg %h expected 0001 7e", digit_en, output_segments);
    end
    wait_cycle(40);
  endtask

  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_value = '0;
    load_blank = '0;
    cur.val    = '0;
    cur.blank  = '0;
    cur.start  = 0;
    test_reset;
    test_load;
    test_back_to_back;
    test_blank;
    test_boundary_load;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
